bch_correct_buffer: RTL and testbench

//  Downstream stage of bch_error_tmec. Stores the received data bits of each codeword in a

---
 rtl/bch_correct_buffer.sv | 193 +++++++++++++++++++
 tb/tb_bch_correct_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_correct_buffer.sv
// ---------------------------------------------------------------------------------------------
// bch_correct_buffer
//
// Holds the received data bits of each BCH codeword in a circular buffer while the decoder
// (syndrome, sigma, Chien search) works. It then XORs the Chien error-locator stream onto the
// buffered data, beat for beat, and emits corrected data in BITS-wide beats.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a received data beat
//   in_ready   buffer can accept a beat this cycle (depends on registered level only)
//   in_data    received data beat, first-received bit in bit 0
//   err_first  err beat is beat 0 of a codeword
//   err_last   err beat is beat BEATS-1 of a codeword
//   err_valid  err holds an error-locator beat (never stalled)
//   err        1 = flip the corresponding data bit
//   out_first  corrected beat 0 of a codeword
//   out_last   corrected beat BEATS-1 of a codeword
//   out_valid  out_data valid (one cycle after the err beat)
//   out_data   corrected data beat
//   level      beats currently stored
//   sync_err   sticky: err stream misaligned or buffer underflow
// ---------------------------------------------------------------------------------------------
module bch_correct_buffer #(
    parameter int unsigned DATA_BITS = 5,
    parameter int unsigned BITS      = 1,
    parameter int unsigned FRAMES    = 2,
    localparam int unsigned BEATS    = (DATA_BITS + BITS - 1) / BITS,
    localparam int unsigned DEPTH    = FRAMES * BEATS,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BITS-1:0]  in_data,
    input  logic             err_first,
    input  logic             err_last,
    input  logic             err_valid,
    input  logic [BITS-1:0]  err,
    output logic             out_first,
    output logic             out_last,
    output logic             out_valid,
    output logic [BITS-1:0]  out_data,
    output logic [CNT_W-1:0] level,
    output logic             sync_err
);

    // Pointer and beat-counter widths are kept at least 1 so DEPTH==1 / BEATS==1 still build.
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Number of valid bits in the last beat; 0 means the last beat is full.
    localparam int unsigned TAIL   = DATA_BITS % BITS;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    logic [BITS-1:0]   mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [BEAT_W-1:0] wr_beat_q,  wr_beat_d;
    logic [BEAT_W-1:0] rd_beat_q,  rd_beat_d;
    logic [CNT_W-1:0]  level_q,    level_d;
    logic              sync_err_q, sync_err_d;

    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q,  out_last_d;
    logic [BITS-1:0]   out_data_q,  out_data_d;

    // -----------------------------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------------------------
    logic            do_wr;
    logic            do_rd;
    logic            underflow;
    logic            misalign;
    logic            rd_is_last;
    logic [BITS-1:0] last_mask;
    logic [BITS-1:0] rd_word;

    // in_ready looks only at the registered level, so a read this cycle frees a slot next cycle.
    assign in_ready  = (level_q != CNT_FULL);
    assign do_wr     = in_valid & in_ready;
    assign do_rd     = err_valid & (level_q != '0);
    assign underflow = err_valid & (level_q == '0);

    assign rd_is_last = (rd_beat_q == BEAT_LAST);

    // Framing flags from the decoder are only cross-checked against our own beat count.
    assign misalign = err_valid & ((err_first & (rd_beat_q != '0)) |
                                   (err_last  & !rd_is_last));

    // Bits beyond DATA_BITS in a partial last beat carry no codeword data.
    always_comb begin
        last_mask = '0;
        for (int i = 0; i < int'(BITS); i++) begin
            last_mask[i] = (TAIL == 0) || (i < int'(TAIL));
        end
    end

    always_comb begin
        rd_word = mem[rd_ptr_q] ^ err;
        if (rd_is_last) begin
            rd_word = rd_word & last_mask;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_beat_d   = wr_beat_q;
        rd_beat_d   = rd_beat_q;
        level_d     = level_q;
        sync_err_d  = sync_err_q | underflow | misalign;
        out_valid_d = do_rd;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;

        if (do_wr) begin
            wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            wr_beat_d = (wr_beat_q == BEAT_LAST) ? '0 : wr_beat_q + BEAT_W'(1);
        end

        if (do_rd) begin
            rd_ptr_d    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            rd_beat_d   = rd_is_last ? '0 : rd_beat_q + BEAT_W'(1);
            out_first_d = (rd_beat_q == '0);
            out_last_d  = rd_is_last;
            out_data_d  = rd_word;
        end

        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_beat_q   <= '0;
            rd_beat_q   <= '0;
            level_q     <= '0;
            sync_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_beat_q   <= wr_beat_d;
            rd_beat_q   <= rd_beat_d;
            level_q     <= level_d;
            sync_err_q  <= sync_err_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Buffer storage is deliberately not reset; level/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_bch_correct_buffer.sv
// ---------------------------------------------------------------------------------------------
// tb_bch_correct_buffer
//
// Directed bench for bch_correct_buffer. dut1 uses DATA_BITS=5, BITS=1, FRAMES=2; dut2 uses
// DATA_BITS=5, BITS=2, FRAMES=2 to exercise the partial last beat.
// ---------------------------------------------------------------------------------------------
module tb_bch_correct_buffer;

    logic       clk = 1'b0;
    logic       rst_n;

    // dut1: BITS=1, BEATS=5, DEPTH=10
    logic       in_valid, in_ready, err_first, err_last, err_valid;
    logic [0:0] in_data, err, out_data;
    logic       out_first, out_last, out_valid, sync_err;
    logic [3:0] level;

    // dut2: BITS=2, BEATS=3, DEPTH=6
    logic       in_valid2, in_ready2, err_first2, err_last2, err_valid2;
    logic [1:0] in_data2, err2, out_data2;
    logic       out_first2, out_last2, out_valid2, sync_err2;
    logic [2:0] level2;

    int total = 0;
    int bad   = 0;
    int rc    = 0;  // dut1 reads since last reset, for framing flags

    always #5 clk = ~clk;

    bch_correct_buffer #(.DATA_BITS(5), .BITS(1), .FRAMES(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .err_first(err_first), .err_last(err_last), .err_valid(err_valid), .err(err),
        .out_first(out_first), .out_last(out_last), .out_valid(out_valid),
        .out_data(out_data), .level(level), .sync_err(sync_err)
    );

    bch_correct_buffer #(.DATA_BITS(5), .BITS(2), .FRAMES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .err_first(err_first2), .err_last(err_last2), .err_valid(err_valid2), .err(err2),
        .out_first(out_first2), .out_last(out_last2), .out_valid(out_valid2),
        .out_data(out_data2), .level(level2), .sync_err(sync_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // One err beat on dut1 with correct framing; checks the registered output after the edge.
    task automatic read1(input logic e, input logic exp_d, input string tag);
        err_valid = 1'b1;
        err       = e;
        err_first = (rc % 5 == 0);
        err_last  = (rc % 5 == 4);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"},  out_data,  exp_d);
        chk({tag, "_first"}, out_first, (rc % 5 == 0));
        chk({tag, "_last"},  out_last,  (rc % 5 == 4));
        rc++;
        err_valid = 1'b0;
        err_first = 1'b0;
        err_last  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        rc = 0;
    endtask

    logic       frame1 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       errs1  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp1   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       fill   [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] in2    [3] = '{2'b01, 2'b11, 2'b11};
    logic [1:0] err2a  [3] = '{2'b00, 2'b00, 2'b00};
    logic [1:0] exp2a  [3] = '{2'b01, 2'b11, 2'b01};
    logic [1:0] err2b  [3] = '{2'b10, 2'b00, 2'b01};
    logic [1:0] exp2b  [3] = '{2'b11, 2'b11, 2'b00};
    logic       q [$];

    initial begin
        rst_n = 1'b0;
        {in_valid, err_first, err_last, err_valid} = '0;
        in_data = '0; err = '0;
        {in_valid2, err_first2, err_last2, err_valid2} = '0;
        in_data2 = '0; err2 = '0;

        // Reset state
        #12;
        chk("rst_level",     level,     4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  1'b0);
        chk("rst_sync_err",  sync_err,  1'b0);
        chk("rst_level2",    level2,    3'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  in_ready,  1'b1);

        // 1: single frame, one flipped bit
        for (int i = 0; i < 5; i++) write1(frame1[i]);
        chk("t1_level", level, 4'd5);
        for (int i = 0; i < 5; i++) read1(errs1[i], exp1[i], "t1");
        tick();
        chk("t1_idle_valid", out_valid, 1'b0);
        chk("t1_level_end",  level,     4'd0);
        chk("t1_sync",       sync_err,  1'b0);

        // 2: BITS=2, partial last beat masked, with and without errors
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid2 = 1'b1;
                in_data2  = in2[i];
                tick();
            end
            in_valid2 = 1'b0;
            chk("t2_level", level2, 3'd3);
            for (int i = 0; i < 3; i++) begin
                err_valid2 = 1'b1;
                err2       = (f == 0) ? err2a[i] : err2b[i];
                err_first2 = (i == 0);
                err_last2  = (i == 2);
                tick();
                chk("t2_valid", out_valid2, 1'b1);
                chk("t2_data",  out_data2,  (f == 0) ? exp2a[i] : exp2b[i]);
                chk("t2_first", out_first2, (i == 0));
                chk("t2_last",  out_last2,  (i == 2));
            end
            err_valid2 = 1'b0;
            err_first2 = 1'b0;
            err_last2  = 1'b0;
            tick();
            chk("t2_idle", out_valid2, 1'b0);
        end
        chk("t2_sync", sync_err2, 1'b0);

        // 3: fill to DEPTH, 11th beat held, one read reopens in_ready
        for (int i = 0; i < 10; i++) write1(fill[i]);
        chk("t3_full_level", level,    4'd10);
        chk("t3_full_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 1'b0;
        tick();
        chk("t3_held_level", level,    4'd10);
        chk("t3_held_ready", in_ready, 1'b0);
        read1(1'b0, fill[0], "t3_first");
        chk("t3_lvl9",   level,    4'd9);
        chk("t3_ready9", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t3_refill", level, 4'd10);
        for (int i = 1; i < 10; i++) read1(1'b0, fill[i], "t3_drain");
        read1(1'b0, 1'b0, "t3_held_beat");
        chk("t3_empty", level,    4'd0);
        chk("t3_sync",  sync_err, 1'b0);

        // 4: write and read every cycle at level 1
        write1(1'b1);
        q.push_back(1'b1);
        for (int i = 0; i < 20; i++) begin
            logic d;
            logic e;
            logic x;
            d = ((i % 3) == 1) ^ (i >= 10);
            e = i[0];
            in_valid = 1'b1;
            in_data  = d;
            q.push_back(d);
            x = q.pop_front();
            read1(e, x ^ e, "t4");
            chk("t4_level", level, 4'd1);
        end
        in_valid = 1'b0;
        read1(1'b0, q.pop_front(), "t4_last");
        chk("t4_empty", level,    4'd0);
        chk("t4_sync",  sync_err, 1'b0);

        // 5a: underflow
        err_valid = 1'b1;
        err       = 1'b0;
        tick();
        err_valid = 1'b0;
        chk("t5_uf_sync",  sync_err,  1'b1);
        chk("t5_uf_valid", out_valid, 1'b0);
        chk("t5_uf_level", level,     4'd0);
        tick();
        chk("t5_sticky", sync_err, 1'b1);

        // 5b: err_first at rd_beat 2 on a fresh buffer
        pulse_reset();
        chk("t5_rst_sync", sync_err, 1'b0);
        write1(1'b1);
        write1(1'b0);
        write1(1'b1);
        read1(1'b0, 1'b1, "t5_b0");
        read1(1'b0, 1'b0, "t5_b1");
        chk("t5_pre_sync", sync_err, 1'b0);
        err_valid = 1'b1;
        err_first = 1'b1;
        err       = 1'b0;
        tick();
        err_valid = 1'b0;
        err_first = 1'b0;
        chk("t5_mis_sync",  sync_err,  1'b1);
        chk("t5_mis_valid", out_valid, 1'b1);
        chk("t5_mis_first", out_first, 1'b0);
        chk("t5_mis_data",  out_data,  1'b1);

        // 6: reset mid-frame at level 3
        pulse_reset();
        write1(1'b1);
        write1(1'b1);
        write1(1'b0);
        write1(1'b1);
        read1(1'b0, 1'b1, "t6_pre");
        chk("t6_pre_level", level, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 1'b0);
        chk("t6_async_level", level,     4'd0);
        #1;
        rst_n = 1'b1;
        rc = 0;
        for (int i = 0; i < 5; i++) write1(frame1[i]);
        chk("t6_level", level, 4'd5);
        for (int i = 0; i < 5; i++) read1(errs1[i], exp1[i], "t6");
        chk("t6_sync",  sync_err, 1'b0);
        chk("t6_empty", level,    4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
